// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window controller: image geometry defaults,
// FSM encoding and the 3x3 tap-to-offset mapping.
package sobel_pkg;

    localparam int IMG_W_DEF  = 64;
    localparam int IMG_H_DEF  = 64;
    localparam int PIX_W_DEF  = 8;
    localparam int ADDR_W_DEF = 12;

    localparam int         N_TAPS     = 9;
    localparam logic [3:0] CENTER_TAP = 4'd4;
    localparam logic [3:0] LAST_TAP   = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Row offset (tap / 3) of a window tap, avoiding a real divider.
    function automatic logic [1:0] tap_row(input logic [3:0] tap);
        logic [1:0] r;
        case (tap)
            4'd0, 4'd1, 4'd2: r = 2'd0;
            4'd3, 4'd4, 4'd5: r = 2'd1;
            4'd6, 4'd7, 4'd8: r = 2'd2;
            default:          r = 2'd0;
        endcase
        return r;
    endfunction

    // Column offset (tap % 3) of a window tap.
    function automatic logic [1:0] tap_col(input logic [3:0] tap);
        logic [1:0] c;
        case (tap)
            4'd0, 4'd3, 4'd6: c = 2'd0;
            4'd1, 4'd4, 4'd7: c = 2'd1;
            4'd2, 4'd5, 4'd8: c = 2'd2;
            default:          c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// Combinational ROM address for tap `tap` of the 3x3 window centred at (x, y).
module sobel_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    input  logic [3:0]        tap,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    // x and y are always >= 1 here, so the -1 never underflows.
    always_comb begin
        row  = y - ADDR_W'(1) + ADDR_W'(tap_row(tap));
        col  = x - ADDR_W'(1) + ADDR_W'(tap_col(tap));
        addr = row * ADDR_W'(IMG_W) + col;
    end

endmodule

// File: rtl/sobel_ctrl.sv
// Frame scanner for a Sobel datapath: fetches each interior pixel's 3x3
// neighbourhood from an image ROM and hands it downstream with valid/ready.
module sobel_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [PIX_W-1:0]     rd_data,
    output logic [9*PIX_W-1:0]   win,
    output logic [ADDR_W-1:0]    win_addr,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t            state_reg;
    logic [ADDR_W-1:0] x_reg;
    logic [ADDR_W-1:0] y_reg;
    logic [3:0]        tap_reg;
    logic              rd_en_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              win_valid_reg;
    logic [ADDR_W-1:0] win_addr_reg;
    logic              done_reg;
    logic              cap_valid_reg;
    logic [3:0]        cap_tap_reg;

    // Position and tap that will be on the read bus after the next edge.
    logic [ADDR_W-1:0] x_next;
    logic [ADDR_W-1:0] y_next;
    logic [3:0]        tap_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] center_addr;
    logic              last_window;

    always_comb begin
        x_next   = x_reg;
        y_next   = y_reg;
        tap_next = 4'(tap_reg + 4'd1);
        case (state_reg)
            ST_IDLE: begin
                x_next   = ONE;
                y_next   = ONE;
                tap_next = 4'd0;
            end
            ST_EMIT: begin
                tap_next = 4'd0;
                if (x_reg < X_LAST) begin
                    x_next = x_reg + ONE;
                end else begin
                    x_next = ONE;
                    y_next = y_reg + ONE;
                end
            end
            default: ;
        endcase
    end

    assign last_window = (x_reg == X_LAST) && (y_reg == Y_LAST);

    sobel_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_fetch_addr (
        .x    (x_next),
        .y    (y_next),
        .tap  (tap_next),
        .addr (fetch_addr)
    );

    // The centre tap's address is exactly y*IMG_W + x.
    sobel_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_center_addr (
        .x    (x_reg),
        .y    (y_reg),
        .tap  (CENTER_TAP),
        .addr (center_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            x_reg         <= ONE;
            y_reg         <= ONE;
            tap_reg       <= 4'd0;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            win_valid_reg <= 1'b0;
            win_addr_reg  <= '0;
            done_reg      <= 1'b0;
            cap_valid_reg <= 1'b0;
            cap_tap_reg   <= 4'd0;
        end else if (abort) begin
            state_reg     <= ST_IDLE;
            x_reg         <= ONE;
            y_reg         <= ONE;
            tap_reg       <= 4'd0;
            rd_en_reg     <= 1'b0;
            win_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            cap_valid_reg <= 1'b0;
        end else begin
            // ROM answers one cycle after the strobe, so remember which tap it was.
            cap_valid_reg <= rd_en_reg;
            cap_tap_reg   <= tap_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg   <= ST_FETCH;
                        x_reg       <= x_next;
                        y_reg       <= y_next;
                        tap_reg     <= tap_next;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= fetch_addr;
                    end
                end
                ST_FETCH: begin
                    if (tap_reg == LAST_TAP) begin
                        state_reg <= ST_WAIT;
                        rd_en_reg <= 1'b0;
                    end else begin
                        tap_reg     <= tap_next;
                        rd_addr_reg <= fetch_addr;
                    end
                end
                ST_WAIT: begin
                    state_reg     <= ST_EMIT;
                    win_valid_reg <= 1'b1;
                    win_addr_reg  <= center_addr;
                end
                ST_EMIT: begin
                    if (win_ready) begin
                        win_valid_reg <= 1'b0;
                        if (last_window) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= ST_FETCH;
                            x_reg       <= x_next;
                            y_reg       <= y_next;
                            tap_reg     <= tap_next;
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= fetch_addr;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    x_reg     <= ONE;
                    y_reg     <= ONE;
                    tap_reg   <= 4'd0;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    rd_en_reg     <= 1'b0;
                    win_valid_reg <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    // One capture register per tap; the window only changes while win_valid is low.
    genvar gi;
    generate
        for (gi = 0; gi < N_TAPS; gi++) begin : g_tap
            logic [PIX_W-1:0] tap_data_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tap_data_reg <= '0;
                end else if (cap_valid_reg && (cap_tap_reg == 4'(gi))) begin
                    tap_data_reg <= rd_data;
                end
            end

            assign win[gi*PIX_W +: PIX_W] = tap_data_reg;
        end
    endgenerate

    assign rd_en     = rd_en_reg;
    assign rd_addr   = rd_addr_reg;
    assign win_valid = win_valid_reg;
    assign win_addr  = win_addr_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sobel_ctrl.sv
// Directed bench for sobel_ctrl: first-window timing, stall, abort, full frame
// with row wrap, and asynchronous reset mid-window.
module tb_sobel_ctrl;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 12;

    // Window (1,1) with ROM data = addr[7:0]: taps 00 01 02 40 41 42 80 81 82.
    localparam logic [71:0] WIN_11 = 72'h82_81_80_42_41_40_02_01_00;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_W-1:0]    rd_data;
    logic [9*PIX_W-1:0]  win;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_valid;
    logic                win_ready;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;

    sobel_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .win       (win),
        .win_addr  (win_addr),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Image ROM: registered read, pixel value = low byte of its address.
    always @(posedge clk) begin
        if (rd_en) rd_data <= rd_addr[7:0];
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] tap_addr(input int x, input int y, input int k);
        return ADDR_W'((y - 1 + k / 3) * IMG_W + (x - 1 + k % 3));
    endfunction

    function automatic logic [71:0] exp_win(input int x, input int y);
        logic [71:0]       w;
        logic [ADDR_W-1:0] a;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            a = tap_addr(x, y, k);
            w[k*8 +: 8] = a[7:0];
        end
        return w;
    endfunction

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!win_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, win_valid, 1'b1);
    endtask

    initial begin
        int hs;
        int dn;
        int mx;
        int my;
        int last_addr;
        logic wrap_pending;
        logic [ADDR_W-1:0] exp_seq [9];

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        win_ready = 1'b0;
        exp_seq   = '{12'd0, 12'd1, 12'd2, 12'd64, 12'd65, 12'd66, 12'd128, 12'd129, 12'd130};

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_rd_en", rd_en, 1'b0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_win_valid", win_valid, 1'b0);
        check_eq("rst_win_addr", win_addr, 0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_win", win, 0);
        $display("reset checked");
        reset = 1'b0;
        @(negedge clk);

        // First window: fetch sequence, WAIT cycle, emit at cycle 11
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("first_rd_en_%0d", k), rd_en, 1'b1);
            check_eq($sformatf("first_rd_addr_%0d", k), rd_addr, exp_seq[k]);
            check_eq($sformatf("first_busy_%0d", k), busy, 1'b1);
            @(negedge clk);
        end
        check_eq("wait_rd_en", rd_en, 1'b0);
        check_eq("wait_win_valid", win_valid, 1'b0);
        @(negedge clk);
        check_eq("first_win_valid", win_valid, 1'b1);
        check_eq("first_win_addr", win_addr, 65);
        check_eq("first_win", win, WIN_11);
        $display("window (1,1) addr=%0d win=%h", win_addr, win);

        // Stall 20 cycles with start asserted (must be ignored while busy)
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("stall_win_valid", win_valid, 1'b1);
            check_eq("stall_win", win, WIN_11);
            check_eq("stall_win_addr", win_addr, 65);
            check_eq("stall_rd_en", rd_en, 1'b0);
        end
        start     = 1'b0;
        win_ready = 1'b1;
        @(negedge clk);
        check_eq("release_win_valid", win_valid, 1'b0);
        check_eq("release_rd_en", rd_en, 1'b1);
        check_eq("release_rd_addr", rd_addr, 1);
        $display("stall released, next fetch addr=%0d", rd_addr);

        // Abort during fetch of window 5
        hs = 1;
        for (int c = 0; c < 200 && hs < 4; c++) begin
            @(negedge clk);
            if (win_valid) hs++;
        end
        check_eq("hs_before_abort", hs, 4);
        @(negedge clk);
        check_eq("w5_rd_en", rd_en, 1'b1);
        check_eq("w5_rd_addr", rd_addr, 4);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_rd_en", rd_en, 1'b0);
        check_eq("abort_win_valid", win_valid, 1'b0);
        check_eq("abort_done", done, 1'b0);
        @(negedge clk);
        check_eq("abort_done_after", done, 1'b0);
        check_eq("abort_busy_after", busy, 1'b0);
        $display("abort taken during window 5 fetch");

        // Full frame from restart, win_ready held high
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_rd_en", rd_en, 1'b1);
        check_eq("restart_rd_addr", rd_addr, 0);
        hs = 0;
        dn = 0;
        mx = 1;
        my = 1;
        last_addr = -1;
        wrap_pending = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            if (wrap_pending) begin
                check_eq("row_wrap_rd_addr", rd_addr, 64);
                check_eq("row_wrap_rd_en", rd_en, 1'b1);
                wrap_pending = 1'b0;
            end
            if (done) dn++;
            if (win_valid) begin
                check_eq("frame_win_addr", win_addr, my * IMG_W + mx);
                check_eq("frame_win", win, exp_win(mx, my));
                hs++;
                last_addr = int'(win_addr);
                if (mx == 62 && my == 1) wrap_pending = 1'b1;
                if (mx < IMG_W - 2) begin
                    mx++;
                end else begin
                    mx = 1;
                    my++;
                end
            end
            if (!busy) break;
            @(negedge clk);
        end
        check_eq("frame_busy_low", busy, 1'b0);
        check_eq("frame_handshakes", hs, 3844);
        check_eq("frame_last_win_addr", last_addr, 4030);
        check_eq("frame_done_pulses", dn, 1);
        $display("frame complete: %0d windows, last addr %0d, %0d done pulse(s)", hs, last_addr, dn);

        // Asynchronous reset between edges during EMIT
        win_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("pre_reset_valid");
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_rd_en", rd_en, 1'b0);
        check_eq("arst_rd_addr", rd_addr, 0);
        check_eq("arst_win_valid", win_valid, 1'b0);
        check_eq("arst_win_addr", win_addr, 0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_win", win, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("post_rst_rd_addr", rd_addr, 0);
        wait_valid("post_rst_valid");
        check_eq("post_rst_win_addr", win_addr, 65);
        check_eq("post_rst_win", win, WIN_11);
        $display("reset mid-emit recovered, window addr=%0d", win_addr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_ctrl.md
SOBEL_CTRL -- requirements
Module: sobel_ctrl

Interface
REQ-001 Parameter IMG_W, default 64, image width in pixels.
REQ-002 Parameter IMG_H, default 64, image height in pixels.
REQ-003 Parameter PIX_W, default 8, pixel width in bits.
REQ-004 Parameter ADDR_W, default 12, pixel address width (IMG_W*IMG_H <= 2**ADDR_W).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  begin one full-frame scan; sampled only in IDLE.
REQ-008 abort  in  1  synchronous; returns to IDLE without done.
REQ-009 rd_en  out  1  image ROM read strobe.
REQ-010 rd_addr  out  ADDR_W  image ROM read address.
REQ-011 rd_data  in  PIX_W  ROM data, valid exactly one cycle after the rd_en cycle.
REQ-012 win  out  9*PIX_W  3x3 window; tap k at bits [k*PIX_W +: PIX_W], k = 3*row + col, row-major from top-left.
REQ-013 win_addr  out  ADDR_W  address of window centre (y*IMG_W + x).
REQ-014 win_valid  out  1  win/win_addr valid.
REQ-015 win_ready  in  1  downstream Sobel datapath accepts window.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after last window accepted.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT, EMIT, DONE.
REQ-019 IDLE: start=1 -> FETCH with x=1, y=1, tap=0; otherwise stay.
REQ-020 FETCH: rd_en=1, rd_addr = (y-1+tap/3)*IMG_W + (x-1+tap%3); tap increments each cycle; after tap 8 -> WAIT.
REQ-021 Data returned in the cycle after tap k is issued SHALL be captured into window register k (including during WAIT for tap 8).
REQ-022 WAIT: one cycle, rd_en=0 -> EMIT.
REQ-023 EMIT: win_valid=1; win, win_addr stable until win_ready=1 sampled high.
REQ-024 On EMIT handshake: x<IMG_W-2 -> x+1, FETCH; else x=1, y+1, FETCH; at (x,y)=(IMG_W-2,IMG_H-2) -> DONE.
REQ-025 Only interior pixels processed: x,y in 1..IMG_W-2 / 1..IMG_H-2; defaults yield 3844 windows per frame.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE.
REQ-027 Latency: start sampled at edge 0 -> FETCH cycles 1..9, WAIT cycle 10, win_valid first high cycle 11; each subsequent window >= 11 cycles after previous handshake.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in any state -> IDLE next cycle; win_valid, rd_en, done low; abort has priority over win_ready and start.
REQ-030 rd_en low in all states but FETCH; win_valid low in all states but EMIT.
REQ-031 Address arithmetic SHALL be computed at ADDR_W bits with no wrap for legal parameters.

Reset
REQ-032 reset=1 SHALL immediately force: state IDLE, x=1, y=1, tap=0, window registers 0, rd_en=0, rd_addr=0, win_valid=0, win_addr=0, busy=0, done=0.
REQ-033 Reset mid-frame SHALL discard progress; next start restarts at (1,1).

Structure
REQ-034 Shared package sobel_pkg SHALL hold IMG_W, IMG_H, PIX_W, ADDR_W defaults and the FSM state encoding.
REQ-035 Tap address computation SHALL be one sub-module sobel_addr_gen (inputs x, y, tap; output address).
REQ-036 Target size 150-300 lines RTL total.

Verification
REQ-037 start pulse after reset -> rd_addr sequence 0,1,2,64,65,66,128,129,130 on cycles 1..9; win_valid cycle 11; win_addr=65.
REQ-038 ROM model data=addr[7:0], win_ready tied 1 -> 3844 handshakes, last win_addr=4030, single done pulse, busy falls after done.
REQ-039 win_ready held 0 for 20 cycles in EMIT -> win, win_addr, win_valid unchanged; no rd_en; advance on release.
REQ-040 Row wrap: handshake at x=62,y=1 -> next window taps start at rd_addr 64, win_addr=129.
REQ-041 abort during FETCH of window 5 -> IDLE next cycle, no done; next start restarts with rd_addr 0.
REQ-042 reset asserted mid-EMIT between clock edges -> outputs zero immediately; start while busy ignored.
